// File: rtl/mem_pll_reset_seq.sv
// mem_pll_reset_seq: power-up / recovery sequencer for the memory-clock PLL.
// Pulses the PLL reset, qualifies the asynchronous lock through a flop chain,
// and holds the memory-domain reset request until lock has been stable for
// LOCK_STABLE cycles. Lock timeouts retry the PLL; lock loss in RUN re-sequences.
// Optional feature macro: MEM_PLL_RETRY_LIMIT_EN. When it is defined, the timeout
// that brings retry_cnt to MAX_RETRIES parks the block in FAIL. When it is not
// defined, the block retries forever and fail is tied low.
module mem_pll_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       mem_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Terminal counts: the counter starts at 0 on every state entry.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d, retry_inc;
    logic                   lost_d;
    logic                   pll_reset_q, mem_reset_q, ready_q, lock_lost_q;

    // Lock synchronizer: only the last stage is ever looked at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    // Next-state, counter and retry bookkeeping; lock has priority over timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        lost_d  = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
`ifdef MEM_PLL_RETRY_LIMIT_EN
                    if (retry_inc == 4'(MAX_RETRIES)) state_d = ST_FAIL;
                    else                              state_d = ST_PLL_RST;
`else
                    state_d = ST_PLL_RST;
`endif
                end
            end
            ST_STABLE: begin
                if (!lock_s)                    state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    lost_d  = 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

`ifdef MEM_PLL_RETRY_LIMIT_EN
    logic fail_q;
    assign fail = fail_q;
`else
    // The retry limit only matters when the limit feature is compiled in.
    logic [3:0] unused_max_retries;
    assign unused_max_retries = 4'(MAX_RETRIES);
    assign fail = 1'b0;
`endif

    // State register with outputs decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            pll_reset_q <= 1'b1;
            mem_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
`ifdef MEM_PLL_RETRY_LIMIT_EN
            fail_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            mem_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            lock_lost_q <= lost_d;
`ifdef MEM_PLL_RETRY_LIMIT_EN
            fail_q      <= (state_d == ST_FAIL);
`endif
        end
    end

    assign pll_reset = pll_reset_q;
    assign mem_reset = mem_reset_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_mem_pll_reset_seq.sv
// Bench for mem_pll_reset_seq: timestamp-based phase model, per-cycle compare
// of every output, hand-computed timing pins, and randomized lock activity.
module tb_mem_pll_reset_seq;

    localparam int SYNC_STAGES    = 2;
    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 64;
    localparam int LOCK_STABLE    = 8;
    localparam int MAX_RETRIES    = 3;
    localparam int CNT_W          = 16;
    localparam int W              = 9;
`ifdef MEM_PLL_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, mem_reset, ready, lock_lost, fail;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: phase plus the edge number on which it was entered.
    int          edge_n  = 0;
    int          m_phase = P_RST;
    int          m_enter = 0;
    int          m_retry = 0;
    bit          m_lost  = 1'b0;
    bit          lq[$];
    logic [W-1:0] exp_q[$];

    mem_pll_reset_seq #(
        .SYNC_STAGES   (SYNC_STAGES),
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .LOCK_STABLE   (LOCK_STABLE),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .mem_reset(mem_reset),
        .ready    (ready),
        .lock_lost(lock_lost),
        .fail     (fail),
        .retry_cnt(retry_cnt)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_vec();
        logic [W-1:0] v;
        v[8]   = (m_phase == P_RST) || (m_phase == P_FAIL);
        v[7]   = (m_phase != P_RUN);
        v[6]   = (m_phase == P_RUN);
        v[5]   = m_lost;
        v[4]   = (m_phase == P_FAIL);
        v[3:0] = 4'(m_retry);
        return v;
    endfunction

    task automatic model_reset();
        edge_n  = 0;
        m_phase = P_RST;
        m_enter = 0;
        m_retry = 0;
        m_lost  = 1'b0;
        lq.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lq.push_back(1'b0);
        exp_q.delete();
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step();
        bit ls;
        int el;
        int nxt;
        edge_n++;
        ls = lq[0];
        void'(lq.pop_front());
        lq.push_back(pll_lock);
        el     = edge_n - m_enter;
        nxt    = m_phase;
        m_lost = 1'b0;
        case (m_phase)
            P_RST:  if (el == PLL_RST_CYCLES) nxt = P_WAIT;
            P_WAIT: begin
                if (ls) nxt = P_STAB;
                else if (el == LOCK_TIMEOUT) begin
                    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                    nxt = (LIMIT_EN && m_retry == MAX_RETRIES) ? P_FAIL : P_RST;
                end
            end
            P_STAB: begin
                if (!ls) nxt = P_WAIT;
                else if (el == LOCK_STABLE) nxt = P_RUN;
            end
            P_RUN: if (!ls) begin nxt = P_RST; m_lost = 1'b1; end
            default: ;
        endcase
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_enter = edge_n;
        end
        exp_q.push_back(model_vec());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // Scoreboard: every output, every cycle, on the falling edge.
    initial begin
        logic [W-1:0] exp_v;
        forever begin
            @(negedge clk);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : model_vec();
            chk("pll_reset", pll_reset, exp_v[8]);
            chk("mem_reset", mem_reset, exp_v[7]);
            chk("ready",     ready,     exp_v[6]);
            chk("lock_lost", lock_lost, exp_v[5]);
            chk("fail",      fail,      exp_v[4]);
            chk("retry_cnt", retry_cnt, exp_v[3:0]);
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    initial begin
        int t0;
        int hold;
        #1 reset = 1'b1;

        // Scenario 1: plain power-up.
        pll_lock = 1'b0;
        do_reset();
        for (int i = 0; i < 50 && pll_reset !== 1'b0; i++) @(negedge clk);
        chk("s1_pll_reset_fall_edge", edge_n, 4);
        wait_edge(10);
        pll_lock = 1'b1;
        t0 = edge_n;
        for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clk);
        chk("s1_release_latency", edge_n - t0, 11);
        chk("s1_mem_reset", mem_reset, 0);
        chk("s1_retry", retry_cnt, 0);

        // Scenario 4: lock loss in RUN, then full re-sequence.
        repeat (5) @(negedge clk);
        t0 = edge_n;
        pll_lock = 1'b0;
        for (int i = 0; i < 20 && lock_lost !== 1'b1; i++) @(negedge clk);
        chk("s4_lost_latency", edge_n - t0, 3);
        chk("s4_mem_reset", mem_reset, 1);
        chk("s4_ready", ready, 0);
        chk("s4_pll_reset", pll_reset, 1);
        pll_lock = 1'b1;
        @(negedge clk);
        chk("s4_lost_single_cycle", lock_lost, 0);
        for (int i = 0; i < 20 && pll_reset !== 1'b0; i++) @(negedge clk);
        chk("s4_pll_reset_width", edge_n - t0, 7);
        for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
        chk("s4_rerelease", edge_n - t0, 16);

        // Scenario 2: one-cycle lock glitch while stable.
        do_reset();
        pll_lock = 1'b1;
        wait_edge(8);
        pll_lock = 1'b0;
        wait_edge(9);
        pll_lock = 1'b1;
        wait_edge(19);
        chk("s2_mem_reset_held", mem_reset, 1);
        for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
        chk("s2_release_edge", edge_n, 20);

        // Scenario 5: asynchronous reset mid-STABLE.
        do_reset();
        pll_lock = 1'b1;
        wait_edge(8);
        #2 reset = 1'b1;
        #1;
        chk("s5_pll_reset", pll_reset, 1);
        chk("s5_mem_reset", mem_reset, 1);
        chk("s5_ready", ready, 0);
        chk("s5_lock_lost", lock_lost, 0);
        chk("s5_fail", fail, 0);
        chk("s5_retry", retry_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50 && pll_reset !== 1'b0; i++) @(negedge clk);
        chk("s5_restart_pll_reset", edge_n, 4);
        for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
        chk("s5_restart_release", edge_n, 13);

        // Scenario 6: lock arrives on the last timeout cycle.
        do_reset();
        pll_lock = 1'b0;
        wait_edge(65);
        pll_lock = 1'b1;
        wait_edge(68);
        chk("s6_retry", retry_cnt, 0);
        chk("s6_pll_reset", pll_reset, 0);
        chk("s6_mem_reset", mem_reset, 1);
        wait_edge(75);
        chk("s6_not_ready_yet", ready, 0);
        wait_edge(76);
        chk("s6_ready", ready, 1);

        // Scenario 3: no lock at all.
        do_reset();
        pll_lock = 1'b0;
        wait_edge(4);
        chk("s3_pll_reset_low", pll_reset, 0);
        wait_edge(68);
        chk("s3_retry1", retry_cnt, 1);
        chk("s3_pll_reset_pulse", pll_reset, 1);
        wait_edge(72);
        chk("s3_pll_reset_low2", pll_reset, 0);
        wait_edge(136);
        chk("s3_retry2", retry_cnt, 2);
        wait_edge(204);
        chk("s3_retry3", retry_cnt, 3);
        chk("s3_fail", fail, LIMIT_EN);
        wait_edge(208);
        chk("s3_pll_reset_208", pll_reset, LIMIT_EN ? 1 : 0);
        wait_edge(1088);
        chk("s3_retry_final", retry_cnt, LIMIT_EN ? 3 : 15);
        wait_edge(1092);
        chk("s3_pll_reset_1092", pll_reset, LIMIT_EN ? 1 : 0);
        chk("s3_fail_final", fail, LIMIT_EN);

        // Randomized lock activity with occasional asynchronous resets.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int s = 0; s < 25; s++) begin
                pll_lock = ($urandom_range(0, 3) != 0);
                hold = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(2, 160));
                repeat (hold) @(negedge clk);
                if ($urandom_range(0, 19) == 0) begin
                    #3 reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
